oqpsk_rcos_mod_param: RTL and testbench

//  Parametrised OQPSK/QPSK baseband modulator with raised-cosine pulse shaping; successor to the fixed
//  13-bit OQPSK shaper. Accepts a serial bit stream over a valid/ready handshake and splits bits

---
 rtl/oqpsk_pkg.sv | 40 ++++
 rtl/rcos_pulse_rom.sv | 32 +++
 rtl/oqpsk_rcos_mod_param.sv | 157 +++++++++++++++
 tb/tb_oqpsk_rcos_mod_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/oqpsk_pkg.sv
// +----------------------------------------------------------------------+
// | oqpsk_pkg: rail state type and raised-cosine pulse generator.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package oqpsk_pkg;

    typedef enum logic [1:0] {
        RAIL_IDLE = 2'd0,
        RAIL_POS  = 2'd1,
        RAIL_NEG  = 2'd2
    } rail_state_e;

    // round(A*sin^2(pi*(k+0.5)/(2*sps))) evaluated as A*(1-cos(2x))/2 with a
    // Taylor series, so the table builds at elaboration without math builtins.
    function automatic int rcos_pulse(input int k, input int sps, input int out_w);
        real pi_c;
        real x;
        real term;
        real c;
        real amp;
        pi_c = 3.14159265358979323846;
        x    = pi_c * real'(2 * k + 1) / real'(2 * sps);
        if (x > pi_c) begin
            x = 2.0 * pi_c - x;
        end
        c    = 1.0;
        term = 1.0;
        for (int n = 1; n <= 20; n++) begin
            term = -term * x * x / real'((2 * n - 1) * (2 * n));
            c    = c + term;
        end
        amp = real'((1 << (out_w - 1)) - 1);
        return $rtoi(amp * (1.0 - c) / 2.0 + 0.5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rcos_pulse_rom.sv
// +----------------------------------------------------------------------+
// | rcos_pulse_rom: dual-read combinational raised-cosine pulse table.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module rcos_pulse_rom
    import oqpsk_pkg::*;
#(
    parameter int OUT_W = 13,
    parameter int SPS   = 32,
    parameter int AW    = $clog2(2 * SPS)
) (
    input  logic [AW-1:0]    addr_a,
    input  logic [AW-1:0]    addr_b,
    output logic [OUT_W-1:0] data_a,
    output logic [OUT_W-1:0] data_b
);

    logic [OUT_W-1:0] pulse_tab [2*SPS];

    for (genvar g = 0; g < 2 * SPS; g++) begin : g_table
        localparam int PVAL = rcos_pulse(g, SPS, OUT_W);
        assign pulse_tab[g] = OUT_W'(PVAL);
    end

    assign data_a = pulse_tab[addr_a];
    assign data_b = pulse_tab[addr_b];

endmodule

`default_nettype wire

// File: rtl/oqpsk_rcos_mod_param.sv
// +----------------------------------------------------------------------+
// | oqpsk_rcos_mod_param: OQPSK/QPSK modulator, raised-cosine shaping.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module oqpsk_rcos_mod_param
    import oqpsk_pkg::*;
#(
    parameter  int OUT_W = 13,
    parameter  int SPS   = 32,
    localparam int AW    = $clog2(2 * SPS)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    OFFSET_EN,
    input  logic                    BitIn,
    input  logic                    BitValid,
    output logic                    BitReady,
    output logic signed [OUT_W-1:0] I,
    output logic signed [OUT_W-1:0] Q,
    output logic                    SampleValid,
    output logic                    Underrun,
    output logic [AW-1:0]           addI,
    output logic [AW-1:0]           addQ
);

    localparam logic [AW-1:0] SPS_A = AW'(SPS);

    logic [AW-1:0]    cnt;
    logic [1:0]       fifo_cnt;
    logic             fifo0;
    logic             fifo1;
    logic             mode_q;
    rail_state_e      rail_i;
    rail_state_e      rail_q;

    logic             push;
    logic [1:0]       avail;
    logic             seq0;
    logic             seq1;
    logic             mode_now;
    logic [1:0]       pop;
    logic             under_nx;
    rail_state_e      rail_i_nx;
    rail_state_e      rail_q_nx;
    logic [AW-1:0]    addq_now;
    logic [OUT_W-1:0] pulse_i;
    logic [OUT_W-1:0] pulse_q;

    assign BitReady = (fifo_cnt != 2'd2);
    assign push     = BitValid & BitReady;
    assign avail    = fifo_cnt + {1'b0, push};
    // Bits in arrival order, with a same-cycle push appended behind the stored ones.
    assign seq0     = (fifo_cnt == 2'd0) ? BitIn : fifo0;
    assign seq1     = (fifo_cnt == 2'd1) ? BitIn : fifo1;
    assign mode_now = (cnt == '0) ? OFFSET_EN : mode_q;
    assign addq_now = mode_now ? (cnt + SPS_A) : cnt;

    always_comb begin
        pop       = 2'd0;
        under_nx  = 1'b0;
        rail_i_nx = rail_i;
        rail_q_nx = rail_q;
        if (EN) begin
            if (cnt == '0) begin
                if (mode_now) begin
                    if (avail != 2'd0) begin
                        pop       = 2'd1;
                        rail_i_nx = seq0 ? RAIL_POS : RAIL_NEG;
                    end else begin
                        rail_i_nx = RAIL_IDLE;
                        under_nx  = 1'b1;
                    end
                end else begin
                    if (avail == 2'd2) begin
                        pop       = 2'd2;
                        rail_i_nx = seq0 ? RAIL_POS : RAIL_NEG;
                        rail_q_nx = seq1 ? RAIL_POS : RAIL_NEG;
                    end else begin
                        rail_i_nx = RAIL_IDLE;
                        rail_q_nx = RAIL_IDLE;
                        under_nx  = 1'b1;
                    end
                end
            end else if (mode_now && (cnt == SPS_A)) begin
                if (avail != 2'd0) begin
                    pop       = 2'd1;
                    rail_q_nx = seq0 ? RAIL_POS : RAIL_NEG;
                end else begin
                    rail_q_nx = RAIL_IDLE;
                    under_nx  = 1'b1;
                end
            end
        end
    end

    rcos_pulse_rom #(
        .OUT_W (OUT_W),
        .SPS   (SPS),
        .AW    (AW)
    ) u_rom (
        .addr_a (cnt),
        .addr_b (addq_now),
        .data_a (pulse_i),
        .data_b (pulse_q)
    );

    function automatic logic signed [OUT_W-1:0] shape(input rail_state_e r,
                                                      input logic [OUT_W-1:0] p);
        case (r)
            RAIL_POS: shape = $signed(p);
            RAIL_NEG: shape = -$signed(p);
            default:  shape = '0;
        endcase
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt         <= '0;
            fifo_cnt    <= 2'd0;
            fifo0       <= 1'b0;
            fifo1       <= 1'b0;
            mode_q      <= 1'b1;
            rail_i      <= RAIL_IDLE;
            rail_q      <= RAIL_IDLE;
            I           <= '0;
            Q           <= '0;
            SampleValid <= 1'b0;
            Underrun    <= 1'b0;
            addI        <= '0;
            addQ        <= '0;
        end else begin
            SampleValid <= EN;
            Underrun    <= under_nx;
            fifo_cnt    <= avail - pop;
            fifo0       <= (pop == 2'd0) ? seq0 : seq1;
            fifo1       <= seq1;
            rail_i      <= rail_i_nx;
            rail_q      <= rail_q_nx;
            if (EN) begin
                cnt  <= cnt + 1'b1;
                I    <= shape(rail_i_nx, pulse_i);
                Q    <= shape(rail_q_nx, pulse_q);
                addI <= cnt;
                addQ <= addq_now;
                if (cnt == '0) begin
                    mode_q <= OFFSET_EN;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_oqpsk_rcos_mod_param.sv
// +----------------------------------------------------------------------+
// | tb_oqpsk_rcos_mod_param: vector-table bench with sample scoreboard.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_oqpsk_rcos_mod_param;

    localparam int OUT_W = 13;
    localparam int SPS   = 4;
    localparam int AW    = 3;

    logic                    CLK;
    logic                    RST;
    logic                    EN;
    logic                    OFFSET_EN;
    logic                    BitIn;
    logic                    BitValid;
    logic                    BitReady;
    logic signed [OUT_W-1:0] I;
    logic signed [OUT_W-1:0] Q;
    logic                    SampleValid;
    logic                    Underrun;
    logic [AW-1:0]           addI;
    logic [AW-1:0]           addQ;

    oqpsk_rcos_mod_param #(
        .OUT_W (OUT_W),
        .SPS   (SPS)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .OFFSET_EN   (OFFSET_EN),
        .BitIn       (BitIn),
        .BitValid    (BitValid),
        .BitReady    (BitReady),
        .I           (I),
        .Q           (Q),
        .SampleValid (SampleValid),
        .Underrun    (Underrun),
        .addI        (addI),
        .addQ        (addQ)
    );

    typedef struct {
        logic en;
        logic off;
        int   ei;
        int   eq;
        int   eai;
        int   eaq;
        logic eu;
    } vec_t;

    int   P [8] = '{156, 1264, 2831, 3939, 3939, 2831, 1264, 156};
    vec_t tbl [$];
    vec_t sb  [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_i   = 0;
    int   last_q   = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic en, input logic off, input int ei, input int eq,
                                input int eai, input int eaq, input logic eu);
        vec_t v;
        v.en = en; v.off = off; v.ei = ei; v.eq = eq; v.eai = eai; v.eaq = eaq; v.eu = eu;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic observe();
        vec_t e;
        if (RST) return;
        if (SampleValid) begin
            if (sb.size() == 0) begin
                chk("spurious_sample", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("I", int'(I), e.ei);
                chk("Q", int'(Q), e.eq);
                chk("addI", int'(addI), e.eai);
                chk("addQ", int'(addQ), e.eaq);
                chk("Underrun", int'(Underrun), int'(e.eu));
                last_i = e.ei;
                last_q = e.eq;
            end
        end else begin
            chk("I_hold", int'(I), last_i);
            chk("Q_hold", int'(Q), last_q);
            chk("Underrun_idle", int'(Underrun), 0);
        end
    endtask

    // Outputs are observed and inputs driven on the falling edge.
    task automatic tick(input vec_t v, input logic bv, input logic bi, input int exp_ready);
        @(negedge CLK);
        observe();
        if (exp_ready >= 0) chk("BitReady", int'(BitReady), exp_ready);
        EN        = v.en;
        OFFSET_EN = v.off;
        BitValid  = bv;
        BitIn     = bi;
        if (v.en) sb.push_back(v);
    endtask

    task automatic push_bit(input logic b, input logic off);
        tick(mk(1'b0, off, 0, 0, 0, 0, 1'b0), 1'b1, b, 1);
    endtask

    task automatic apply();
        foreach (tbl[i]) tick(tbl[i], 1'b0, 1'b0, -1);
        tbl.delete();
    endtask

    task automatic do_reset(input logic off);
        @(negedge CLK);
        observe();
        chk("scoreboard_drained", sb.size(), 0);
        RST = 1'b1; EN = 1'b0; BitValid = 1'b0; OFFSET_EN = off;
        #1;
        chk("rst_I", int'(I), 0);
        chk("rst_Q", int'(Q), 0);
        chk("rst_SampleValid", int'(SampleValid), 0);
        chk("rst_Underrun", int'(Underrun), 0);
        chk("rst_BitReady", int'(BitReady), 1);
        @(negedge CLK);
        RST = 1'b0;
        last_i = 0;
        last_q = 0;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; OFFSET_EN = 1'b1; BitIn = 1'b0; BitValid = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // No bits at all: silence, underrun at each rail load.
        do_reset(1'b1);
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b1, 1'b1, 0, 0, k, (k + 4) % 8, (k == 0) || (k == 4)));
        apply();
        tick(mk(1'b0, 1'b1, 0, 0, 0, 0, 1'b0), 1'b0, 1'b0, 1);

        // OQPSK with bits 1,0, then I underruns at the next boundary.
        do_reset(1'b1);
        push_bit(1'b1, 1'b1);
        push_bit(1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            if (k < 4)      tbl.push_back(mk(1'b1, 1'b1, P[k], 0, k, k + 4, 1'b0));
            else if (k < 8) tbl.push_back(mk(1'b1, 1'b1, P[k], -P[k-4], k, k - 4, 1'b0));
            else            tbl.push_back(mk(1'b1, 1'b1, 0, -P[k-4], k - 8, k - 4, k == 8));
        end
        apply();

        // QPSK with bits 1,1.
        do_reset(1'b0);
        push_bit(1'b1, 1'b0);
        push_bit(1'b1, 1'b0);
        tick(mk(1'b0, 1'b0, 0, 0, 0, 0, 1'b0), 1'b0, 1'b0, 0);
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b1, 1'b0, P[k], P[k], k, k, 1'b0));
        apply();

        // QPSK with a single bit: underrun, bit kept and used once a partner arrives.
        do_reset(1'b0);
        push_bit(1'b1, 1'b0);
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b1, 1'b0, 0, 0, k, k, k == 0));
        apply();
        push_bit(1'b0, 1'b0);
        tick(mk(1'b0, 1'b0, 0, 0, 0, 0, 1'b0), 1'b0, 1'b0, 0);
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b1, 1'b0, P[k], -P[k], k, k, 1'b0));
        apply();

        // EN toggling every cycle: same sample stream, outputs hold between.
        do_reset(1'b1);
        push_bit(1'b1, 1'b1);
        push_bit(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(mk(1'b1, 1'b1, P[k], (k < 4) ? 0 : -P[k-4], k, (k + 4) % 8, 1'b0));
            tbl.push_back(mk(1'b0, 1'b1, 0, 0, 0, 0, 1'b0));
        end
        apply();

        // Mode drop at cnt 3 takes effect only at the next boundary.
        do_reset(1'b1);
        push_bit(1'b1, 1'b1);
        push_bit(1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b1, (k < 3), P[k], (k < 4) ? 0 : -P[k-4], k, (k + 4) % 8, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 0, 0, 0, 0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 0, 0, 1, 1, 1'b0));
        apply();

        // Mode drop at cnt 3, reset at cnt 5 with a bit buffered: the bit is lost.
        do_reset(1'b1);
        push_bit(1'b1, 1'b1);
        push_bit(1'b0, 1'b1);
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1'b1, (k < 3), P[k], (k < 4) ? 0 : -P[k-4], k, (k + 4) % 8, 1'b0));
        apply();
        push_bit(1'b1, 1'b0);
        do_reset(1'b1);
        tbl.push_back(mk(1'b1, 1'b1, 0, 0, 0, 4, 1'b1));
        apply();
        tick(mk(1'b0, 1'b1, 0, 0, 0, 0, 1'b0), 1'b0, 1'b0, 1);
        tick(mk(1'b0, 1'b1, 0, 0, 0, 0, 1'b0), 1'b0, 1'b0, -1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
